// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (see dmem_port_arbiter.sv).
package dmem_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } arb_state_e;

  // Requester index: 0 = core load/store unit, 1 = loader/DMA.
  typedef logic req_idx_t;

  // Memory DMCtrl size/sign codes.
  localparam logic [2:0] CTRL_B    = 3'b000;
  localparam logic [2:0] CTRL_H    = 3'b001;
  localparam logic [2:0] CTRL_W    = 3'b010;
  localparam logic [2:0] CTRL_BU   = 3'b100;
  localparam logic [2:0] CTRL_HU   = 3'b101;
  localparam logic [2:0] CTRL_NONE = 3'b111;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((ctrl == CTRL_H || ctrl == CTRL_HU) && addr_lo[0]) mis = 1'b1;
    if (ctrl == CTRL_W && addr_lo != 2'b00)                mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/dmem_arb_picker.sv
// Two-way combinational grant picker: a held lock wins outright, otherwise
// fixed priority (ARB_MODE 0) or round-robin on the last winner (ARB_MODE 1).
module dmem_arb_picker
  import dmem_arb_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic [1:0] valid,
  input  req_idx_t   rr_last,
  input  logic       locked,
  input  req_idx_t   owner,
  output logic [1:0] grant
);

  // One-hot grant; an idle lock owner still blocks the other requester.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = 2'b00;
    if (locked) begin
      grant[owner] = 1'b1;
    end else begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (ARB_MODE == 0 || rr_last) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates a single-port data memory between the core LSU (0) and the
// loader/DMA (1): valid/ready requests, registered 1-cycle responses and
// lockable bursts bounded by MAX_BURST transfers and LOCK_TIMEOUT idle cycles.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- misaligned H/W accesses are
// accepted but not forwarded, and answered with rsp_err.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ARB_MODE     = 0,
  parameter int MAX_BURST    = 8,
  parameter int LOCK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_we,
  input  logic [1:0][2:0]  req_ctrl,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0]       req_lock,
  output logic [1:0]       rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_err,
  output logic             mem_we,
  output logic [2:0]       mem_ctrl,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(LOCK_TIMEOUT + 2);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
  localparam logic [IW-1:0] IDLE_LIMIT  = IW'(LOCK_TIMEOUT);

  arb_state_e    state_q, state_d;
  req_idx_t      owner_q, owner_d;
  req_idx_t      rr_last_q, rr_last_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_err_q, rsp_err_d;

  logic [1:0]    grant;
  logic          lock_active;
  req_idx_t      g;
  logic          xfer;
  logic          misal;
  logic [BW-1:0] burst_nxt;
  logic [IW-1:0] idle_nxt;

  assign lock_active = (state_q == S_LOCK);

  dmem_arb_picker #(
    .ARB_MODE(ARB_MODE)
  ) u_picker (
    .valid  (req_valid),
    .rr_last(rr_last_q),
    .locked (lock_active),
    .owner  (owner_q),
    .grant  (grant)
  );

  // Handshake and memory-side mux; nothing reaches memory while reset is held.
  always_comb begin
    g         = grant[1];
    req_ready = grant & req_valid & {2{rst_n}};
    xfer      = |req_ready;
`ifdef DMEM_ALIGN_CHECK_EN
    misal     = xfer && is_misaligned(req_ctrl[g], req_addr[g][1:0]);
`else
    misal     = 1'b0;
`endif
    mem_we    = 1'b0;
    mem_ctrl  = CTRL_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (xfer && !misal) begin
      mem_we    = req_we[g];
      mem_ctrl  = req_ctrl[g];
      mem_addr  = req_addr[g];
      mem_wdata = req_wdata[g];
    end
  end

  // Next-state: response capture, round-robin pointer, lock/burst/idle tracking.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    burst_nxt   = burst_cnt_q + BW'(1);
    idle_nxt    = idle_cnt_q + IW'(1);

    rsp_valid_d = req_ready;
    rsp_err_d   = misal ? req_ready : 2'b00;
    rsp_rdata_d = (xfer && !req_we[g] && !misal) ? mem_rdata : 32'h0;

    if (xfer) rr_last_d = g;

    unique case (state_q)
      S_IDLE: begin
        if (xfer && req_lock[g] && MAX_BURST > 1) begin
          state_d     = S_LOCK;
          owner_d     = g;
          burst_cnt_d = BW'(1);
          idle_cnt_d  = '0;
        end
      end
      S_LOCK: begin
        if (xfer) begin
          idle_cnt_d  = '0;
          burst_cnt_d = burst_nxt;
          if (!req_lock[g] || burst_nxt == BURST_LIMIT) begin
            state_d     = S_IDLE;
            burst_cnt_d = '0;
          end
        end else if (!req_valid[owner_q]) begin
          idle_cnt_d = idle_nxt;
          if (idle_nxt >= IDLE_LIMIT) begin
            state_d     = S_IDLE;
            idle_cnt_d  = '0;
            burst_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and response registers; reset drops any lock and pending response.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a fixed-priority and a round-robin instance share
// one stimulus stream; each has its own behavioural memory and reference model.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAX_BURST    = 8;
  localparam int LOCK_TIMEOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, req_we, req_lock;
  logic [1:0][2:0]  req_ctrl;
  logic [1:0][31:0] req_addr, req_wdata;

  // Index 0 = fixed-priority instance, 1 = round-robin instance.
  logic [1:0]  req_ready [2];
  logic [1:0]  rsp_valid [2];
  logic [1:0]  rsp_err   [2];
  logic [31:0] rsp_rdata [2];
  logic        mem_we    [2];
  logic [2:0]  mem_ctrl  [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  dmem_port_arbiter #(.ARB_MODE(0), .MAX_BURST(MAX_BURST), .LOCK_TIMEOUT(LOCK_TIMEOUT)) u_fixed (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_we(req_we), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lock(req_lock), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .mem_we(mem_we[0]), .mem_ctrl(mem_ctrl[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_port_arbiter #(.ARB_MODE(1), .MAX_BURST(MAX_BURST), .LOCK_TIMEOUT(LOCK_TIMEOUT)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_we(req_we), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lock(req_lock), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .mem_we(mem_we[1]), .mem_ctrl(mem_ctrl[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // ---------------- behavioural memory (little-endian, 256 bytes) ----------------
  function automatic logic [31:0] load_val(input logic [2:0] c, input logic [7:0] b0, b1, b2, b3);
    case (c)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int store_len(input logic [2:0] c);
    case (c)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  logic [7:0] env_mem   [2][256];
  logic [7:0] model_mem [2][256];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = load_val(mem_ctrl[i],
                              env_mem[i][mem_addr[i][7:0]],
                              env_mem[i][8'(mem_addr[i][7:0] + 8'd1)],
                              env_mem[i][8'(mem_addr[i][7:0] + 8'd2)],
                              env_mem[i][8'(mem_addr[i][7:0] + 8'd3)]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int j = 0; j < 256; j++) env_mem[i][j] <= 8'h00;
      end else if (mem_we[i]) begin
        for (int k = 0; k < store_len(mem_ctrl[i]); k++)
          env_mem[i][8'(mem_addr[i][7:0] + 8'(k))] <= mem_wdata[i][8*k +: 8];
      end
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=0x%08h expected=0x%08h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_owner [2];   // -1 when no lock is held
  int         m_cnt   [2];   // transfers made under the current lock
  int         m_idle  [2];   // consecutive cycles the owner left valid low
  int         m_last  [2];   // last requester that transferred
  logic [1:0] exp_rv  [2];
  logic [1:0] exp_err [2];
  logic [31:0] exp_rd [2];
  logic [1:0] obs_ready [2];

  function automatic logic misaligned_ref(input logic [2:0] c, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return ((c == 3'b001 || c == 3'b101) && a[0]) || (c == 3'b010 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_cnt[i] = 0; m_idle[i] = 0; m_last[i] = 1;
      exp_rv[i] = 2'b00; exp_err[i] = 2'b00; exp_rd[i] = 32'h0;
      for (int j = 0; j < 256; j++) model_mem[i][j] = 8'h00;
    end
  endtask

  task automatic model_store(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < store_len(c); k++)
      model_mem[i][8'(a[7:0] + 8'(k))] = d[8*k +: 8];
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic do_cycle();
    int w;
    logic mis;
    logic [1:0] er;
    logic [7:0] a;
    #1;
    for (int i = 0; i < 2; i++) begin
      w = -1;
      if (m_owner[i] >= 0) begin
        if (req_valid[m_owner[i]]) w = m_owner[i];
      end else if (req_valid == 2'b11) begin
        w = (i == 0) ? 0 : 1 - m_last[i];
      end else if (req_valid == 2'b01) begin
        w = 0;
      end else if (req_valid == 2'b10) begin
        w = 1;
      end
      er = 2'b00;
      mis = 1'b0;
      if (w >= 0) begin
        er[w] = 1'b1;
        mis = misaligned_ref(req_ctrl[w], req_addr[w]);
      end
      obs_ready[i] = req_ready[i];
      check($sformatf("ready_i%0d", i), 32'(req_ready[i]), 32'(er));

      if (w >= 0 && !mis) begin
        check($sformatf("mem_we_i%0d", i),    32'(mem_we[i]),   32'(req_we[w]));
        check($sformatf("mem_ctrl_i%0d", i),  32'(mem_ctrl[i]), 32'(req_ctrl[w]));
        check($sformatf("mem_addr_i%0d", i),  mem_addr[i],      req_addr[w]);
        check($sformatf("mem_wdata_i%0d", i), mem_wdata[i],     req_wdata[w]);
      end else if (w >= 0) begin
        check($sformatf("mis_we_i%0d", i), 32'(mem_we[i]), 32'h0);
      end else begin
        check($sformatf("idle_we_i%0d", i),   32'(mem_we[i]),   32'h0);
        check($sformatf("idle_ctrl_i%0d", i), 32'(mem_ctrl[i]), 32'h7);
        check($sformatf("idle_addr_i%0d", i), mem_addr[i],      32'h0);
      end

      exp_rv[i]  = er;
      exp_err[i] = mis ? er : 2'b00;
      exp_rd[i]  = 32'h0;
      if (w >= 0 && !mis) begin
        a = req_addr[w][7:0];
        if (req_we[w])
          model_store(i, req_ctrl[w], req_addr[w], req_wdata[w]);
        else
          exp_rd[i] = load_val(req_ctrl[w], model_mem[i][a], model_mem[i][8'(a + 8'd1)],
                               model_mem[i][8'(a + 8'd2)], model_mem[i][8'(a + 8'd3)]);
      end

      if (w >= 0) begin
        m_last[i] = w;
        if (m_owner[i] < 0) begin
          if (req_lock[w] && MAX_BURST > 1) begin
            m_owner[i] = w; m_cnt[i] = 1; m_idle[i] = 0;
          end
        end else begin
          m_cnt[i]++;
          m_idle[i] = 0;
          if (!req_lock[w] || m_cnt[i] == MAX_BURST) m_owner[i] = -1;
        end
      end else if (m_owner[i] >= 0) begin
        m_idle[i]++;
        if (m_idle[i] >= LOCK_TIMEOUT) m_owner[i] = -1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rsp_valid_i%0d", i), 32'(rsp_valid[i]), 32'(exp_rv[i]));
      check($sformatf("rsp_err_i%0d", i),   32'(rsp_err[i]),   32'(exp_err[i]));
      if (exp_rv[i] != 2'b00)
        check($sformatf("rsp_rdata_i%0d", i), rsp_rdata[i], exp_rd[i]);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_we = we; req_lock = lk;
    for (int j = 0; j < 2; j++) begin
      req_ctrl[j] = c; req_addr[j] = a + 32'(j * 4); req_wdata[j] = d ^ 32'(j);
    end
  endtask

  function automatic logic [2:0] rand_ctrl();
    if ($urandom_range(0, 9) == 0) return 3'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0:       return CTRL_B;
      1:       return CTRL_H;
      2:       return CTRL_W;
      3:       return CTRL_BU;
      default: return CTRL_HU;
    endcase
  endfunction

  task automatic rand_inputs(input int pv, input int pl);
    for (int j = 0; j < 2; j++) begin
      req_valid[j] = ($urandom_range(0, 99) < pv);
      req_we[j]    = 1'($urandom_range(0, 1));
      req_lock[j]  = ($urandom_range(0, 99) < pl);
      req_ctrl[j]  = rand_ctrl();
      req_addr[j]  = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
      req_wdata[j] = $urandom();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run;
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 2'b00, CTRL_W, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_rsp_valid_i%0d", i), 32'(rsp_valid[i]), 32'h0);
      check($sformatf("rst_rsp_rdata_i%0d", i), rsp_rdata[i], 32'h0);
      check($sformatf("rst_rsp_err_i%0d", i),   32'(rsp_err[i]), 32'h0);
      check($sformatf("rst_mem_ctrl_i%0d", i),  32'(mem_ctrl[i]), 32'h7);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Both valid, no lock: round-robin alternates from requester 0, fixed stays on 0.
    for (int n = 0; n < 4; n++) begin
      drive(2'b11, 2'b00, 2'b00, CTRL_W, 32'h20, 32'h0);
      do_cycle();
      check("t2_fixed_grant", 32'(obs_ready[0]), 32'h1);
      check("t2_rr_grant",    32'(obs_ready[1]), (n % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Requester 0 stores a word then loads it back.
    drive(2'b01, 2'b01, 2'b00, CTRL_W, 32'h10, 32'hDEADBEEF);
    do_cycle();
    drive(2'b01, 2'b00, 2'b00, CTRL_W, 32'h10, 32'h0);
    do_cycle();
    for (int i = 0; i < 2; i++) check($sformatf("t1_lw_i%0d", i), rsp_rdata[i], 32'hDEADBEEF);

    // Requester 1 holds a lock with requester 0 waiting: burst capped at MAX_BURST.
    run = 0;
    for (int n = 0; n < MAX_BURST + 1; n++) begin
      drive(2'b11, 2'b00, 2'b10, CTRL_B, 32'h30, 32'h0);
      do_cycle();
      if (n < MAX_BURST && obs_ready[1] == 2'b10) run++;
    end
    check("t3_burst_len",     32'(run), 32'(MAX_BURST));
    check("t3_after_release", 32'(obs_ready[1]), 32'h1);

    // Requester 1 locks then goes idle: requester 0 waits exactly LOCK_TIMEOUT cycles.
    drive(2'b10, 2'b00, 2'b10, CTRL_W, 32'h8, 32'h0);
    do_cycle();
    for (int n = 0; n <= LOCK_TIMEOUT; n++) begin
      drive(2'b01, 2'b00, 2'b00, CTRL_W, 32'h8, 32'h0);
      do_cycle();
      for (int i = 0; i < 2; i++)
        check($sformatf("t4_ready0_i%0d_c%0d", i, n), 32'(obs_ready[i][0]), (n == LOCK_TIMEOUT) ? 32'h1 : 32'h0);
    end

    // Odd-address halfword store then byte load at the same address.
    drive(2'b01, 2'b01, 2'b00, CTRL_H, 32'h21, 32'h0000A5C3);
    do_cycle();
    drive(2'b01, 2'b00, 2'b00, CTRL_B, 32'h21, 32'h0);
    do_cycle();

    // Reset in the middle of a locked load burst.
    drive(2'b01, 2'b00, 2'b01, CTRL_W, 32'h10, 32'h0);
    do_cycle();
    drive(2'b01, 2'b00, 2'b01, CTRL_W, 32'h10, 32'h0);
    do_cycle();
    drive(2'b01, 2'b00, 2'b01, CTRL_W, 32'h10, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_ready_i%0d", i),  32'(req_ready[i]), 32'h0);
      check($sformatf("t6_mem_we_i%0d", i), 32'(mem_we[i]),    32'h0);
      check($sformatf("t6_rsp_now_i%0d", i), 32'(rsp_valid[i]), 32'h0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("t6_rsp_edge_i%0d", i), 32'(rsp_valid[i]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(2'b11, 2'b00, 2'b00, CTRL_W, 32'h4, 32'h0);
    do_cycle();
    for (int i = 0; i < 2; i++)
      check($sformatf("t6_first_grant_i%0d", i), 32'(obs_ready[i]), 32'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      rand_inputs(((n / 100) % 2 == 0) ? 55 : 92, 70);
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
